stack_exec: RTL
===============

STACK_EXEC -- requirements
Module: stack_exec

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock.
REQ-002 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have in_valid  input  1  instruction offered.
REQ-004 SHALL have in_ready  output  1  block can accept an instruction.
REQ-005 SHALL have in_opcode  input  3  000 NOP, 001 PUSHI, 010 POP, 011 DUP, 100 ADD, 101 SUB, 110 AND, 111 SWAP.
REQ-006 SHALL have in_imm  input  8  immediate for PUSHI.
REQ-007 SHALL have stk_top / stk_top_mo  input  8 each  top and top-minus-one from the stack.
REQ-008 SHALL have stk_en, stk_op_en, stk_op  output  1 each  stack enable, op enable, 1=push/0=pop.
REQ-009 SHALL have stk_data  output  8  push data to the stack.
REQ-010 SHALL have done  output  1  one-cycle completion pulse.
REQ-011 SHALL have err  output  1  valid with done; instruction rejected.
REQ-012 SHALL have result  output  8  valid with done.
REQ-013 SHALL have depth  output  6  tracked stack occupancy, 0..32.

Function
REQ-014 SHALL use states IDLE, ISSUE, RESP; in_ready=1 only in IDLE.
REQ-015 SHALL accept an instruction on a rising edge with in_valid=1 in IDLE, capturing opcode, in_imm, stk_top (T), stk_top_mo (M) in that edge.
REQ-016 SHALL check legality at acceptance: depth<1 for POP/DUP, depth<2 for ADD/SUB/AND/SWAP, or depth=32 for PUSHI/DUP -> RESP with err=1, no stack ops, depth unchanged.
REQ-017 SHALL on a legal instruction go to ISSUE and emit one stack op per cycle, stk_en=stk_op_en=1 for exactly those cycles, in order: NOP none (ISSUE skipped); PUSHI push imm; POP pop; DUP push T; ADD/SUB/AND pop, pop, push R; SWAP pop, pop, push T, push M.
REQ-018 SHALL compute R as M+T, M-T or M&T, modulo 256, no flags.
REQ-019 SHALL set result: PUSHI imm, POP T, DUP T, ADD/SUB/AND R, SWAP T, NOP 0x00, error 0x00.
REQ-020 SHALL update depth by +1 per push and -1 per pop in the cycle the op is issued.
REQ-021 SHALL enter RESP the cycle after the last op, assert done for that single cycle, then return to IDLE; latency from acceptance edge to done = number of ops + 1 cycles (NOP 1, PUSHI 2, ADD 4, SWAP 5).
REQ-022 SHALL hold stk_en, stk_op_en, stk_data, stk_op at 0 outside issued ops.
REQ-023 SHALL ignore in_valid outside IDLE; an instruction held through busy cycles is accepted on the first IDLE edge.

Reset
REQ-024 SHALL on reset=1 at any edge, including mid-sequence, enter IDLE, abort pending ops, set depth=0, done=0, err=0, result=0x00, stk_data=0x00.
REQ-025 SHALL drive stk_en=1, stk_op_en=0 while reset is high so the stack clears in the same edges; in_ready=0 while reset is high.

Configuration
REQ-026 SHALL gate SWAP with macro STACK_EXEC_SWAP_EN: defined -> SWAP per REQ-017; undefined -> opcode 111 rejected as illegal (err=1, latency 1, no stack ops).

Verification
REQ-027 SHALL cover: reset, PUSHI 0x05, PUSHI 0x03, ADD -> ops push,push,pop,pop,push 0x08; ADD done 4 cycles after acceptance, result 0x08, depth 1.
REQ-028 SHALL cover: depth 2 holding 0x02 (M), 0x07 (T), SUB -> result 0xFB, depth 1.
REQ-029 SHALL cover: depth 0, POP -> done with err=1 one cycle after acceptance, no stk_en pulses, depth 0.
REQ-030 SHALL cover: 32 PUSHI then PUSHI 0xAA -> err=1, depth stays 32, no push issued.
REQ-031 SHALL cover: reset asserted in second ISSUE cycle of ADD -> no further ops, depth 0, done never pulses, in_ready returns first cycle after reset drops.
REQ-032 SHALL cover: depth 2 holding 0x11 (M), 0x22 (T), SWAP -> with STACK_EXEC_SWAP_EN stack ends top 0x11, MO 0x22, done at cycle 5; without it err=1, stack unchanged.

Source files
------------

// File: rtl/stack_exec.sv
// ============================================================================
// Module   : stack_exec
// Brief    : Sequences stack push/pop operations for a small 8-bit stack ISA.
//            The SWAP opcode exists only when STACK_EXEC_SWAP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_exec (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_opcode,
    input  logic [7:0] in_imm,
    input  logic [7:0] stk_top,
    input  logic [7:0] stk_top_mo,
    output logic       stk_en,
    output logic       stk_op_en,
    output logic       stk_op,
    output logic [7:0] stk_data,
    output logic       done,
    output logic       err,
    output logic [7:0] result,
    output logic [5:0] depth
);

    localparam logic [2:0] c_OP_NOP   = 3'b000;
    localparam logic [2:0] c_OP_PUSHI = 3'b001;
    localparam logic [2:0] c_OP_POP   = 3'b010;
    localparam logic [2:0] c_OP_DUP   = 3'b011;
    localparam logic [2:0] c_OP_ADD   = 3'b100;
    localparam logic [2:0] c_OP_SUB   = 3'b101;
    localparam logic [2:0] c_OP_AND   = 3'b110;
    localparam logic [2:0] c_OP_SWAP  = 3'b111;
    localparam logic [5:0] c_DEPTH_MAX = 6'd32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t     r_state;
    logic [2:0] r_opcode;
    logic [7:0] r_imm;
    logic [7:0] r_t;
    logic [7:0] r_m;
    logic [7:0] r_alu;
    logic [2:0] r_step;
    logic [2:0] r_nOps;
    logic       r_stkEn;
    logic       r_stkOp;
    logic [7:0] r_stkData;
    logic       r_done;
    logic       r_err;
    logic [7:0] r_result;
    logic [5:0] r_depth;

    logic [7:0] w_alu;
    logic [2:0] w_nOps;
    logic       w_illegal;
    logic [7:0] w_res;
    logic [8:0] w_firstOp;
    logic [8:0] w_nextOp;

    // Returns {push, data} for the given step of an instruction's op sequence.
    function automatic logic [8:0] stepOp(input logic [2:0] opc, input logic [2:0] step,
                                          input logic [7:0] imm, input logic [7:0] t,
                                          input logic [7:0] m, input logic [7:0] alu);
        logic [8:0] op;
        op = 9'h000;
        case (opc)
            c_OP_PUSHI: op = {1'b1, imm};
            c_OP_DUP:   op = {1'b1, t};
            c_OP_ADD, c_OP_SUB, c_OP_AND:
                op = (step == 3'd2) ? {1'b1, alu} : 9'h000;
            c_OP_SWAP: begin
                if (step == 3'd2)      op = {1'b1, t};
                else if (step == 3'd3) op = {1'b1, m};
                else                   op = 9'h000;
            end
            default: op = 9'h000;
        endcase
        return op;
    endfunction

    always_comb begin
        w_alu     = 8'h00;
        w_nOps    = 3'd0;
        w_illegal = 1'b0;
        w_res     = 8'h00;
        case (in_opcode)
            c_OP_NOP: ;
            c_OP_PUSHI: begin
                w_nOps    = 3'd1;
                w_illegal = (r_depth == c_DEPTH_MAX);
                w_res     = in_imm;
            end
            c_OP_POP: begin
                w_nOps    = 3'd1;
                w_illegal = (r_depth == 6'd0);
                w_res     = stk_top;
            end
            c_OP_DUP: begin
                w_nOps    = 3'd1;
                w_illegal = (r_depth == 6'd0) || (r_depth == c_DEPTH_MAX);
                w_res     = stk_top;
            end
            c_OP_ADD, c_OP_SUB, c_OP_AND: begin
                if (in_opcode == c_OP_ADD)      w_alu = stk_top_mo + stk_top;
                else if (in_opcode == c_OP_SUB) w_alu = stk_top_mo - stk_top;
                else                            w_alu = stk_top_mo & stk_top;
                w_nOps    = 3'd3;
                w_illegal = (r_depth < 6'd2);
                w_res     = w_alu;
            end
            c_OP_SWAP: begin
`ifdef STACK_EXEC_SWAP_EN
                w_nOps    = 3'd4;
                w_illegal = (r_depth < 6'd2);
                w_res     = stk_top;
`else
                w_illegal = 1'b1;
`endif
            end
            default: ;
        endcase
        if (w_illegal) begin
            w_res = 8'h00;
        end
    end

    assign w_firstOp = stepOp(in_opcode, 3'd0, in_imm, stk_top, stk_top_mo, w_alu);
    assign w_nextOp  = stepOp(r_opcode, r_step, r_imm, r_t, r_m, r_alu);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_opcode  <= 3'd0;
            r_imm     <= 8'h00;
            r_t       <= 8'h00;
            r_m       <= 8'h00;
            r_alu     <= 8'h00;
            r_step    <= 3'd0;
            r_nOps    <= 3'd0;
            r_stkEn   <= 1'b0;
            r_stkOp   <= 1'b0;
            r_stkData <= 8'h00;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_result  <= 8'h00;
            r_depth   <= 6'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_opcode <= in_opcode;
                        r_imm    <= in_imm;
                        r_t      <= stk_top;
                        r_m      <= stk_top_mo;
                        r_alu    <= w_alu;
                        r_nOps   <= w_nOps;
                        r_err    <= w_illegal;
                        r_result <= w_res;
                        if (w_illegal || (w_nOps == 3'd0)) begin
                            r_state <= RESP;
                            r_done  <= 1'b1;
                        end else begin
                            // First op goes out in the cycle right after acceptance.
                            r_state   <= ISSUE;
                            r_stkEn   <= 1'b1;
                            r_stkOp   <= w_firstOp[8];
                            r_stkData <= w_firstOp[7:0];
                            r_depth   <= w_firstOp[8] ? r_depth + 6'd1 : r_depth - 6'd1;
                            r_step    <= 3'd1;
                        end
                    end
                end
                ISSUE: begin
                    if (r_step == r_nOps) begin
                        r_state   <= RESP;
                        r_done    <= 1'b1;
                        r_stkEn   <= 1'b0;
                        r_stkOp   <= 1'b0;
                        r_stkData <= 8'h00;
                    end else begin
                        r_stkEn   <= 1'b1;
                        r_stkOp   <= w_nextOp[8];
                        r_stkData <= w_nextOp[7:0];
                        r_depth   <= w_nextOp[8] ? r_depth + 6'd1 : r_depth - 6'd1;
                        r_step    <= r_step + 3'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // While reset is high the stack sees enable without op-enable, i.e. a clear.
    assign in_ready  = (r_state == IDLE) && !reset;
    assign stk_en    = reset | r_stkEn;
    assign stk_op_en = r_stkEn & ~reset;
    assign stk_op    = r_stkOp & ~reset;
    assign stk_data  = reset ? 8'h00 : r_stkData;
    assign done      = r_done;
    assign err       = r_err;
    assign result    = r_result;
    assign depth     = r_depth;

endmodule

`default_nettype wire
